// File: rtl/sm3_pkg.sv
// Shared SM3 constants, pad FSM state type and a small popcount helper.
package sm3_pkg;

    localparam int          SM3_BLK_WORDS   = 16;
    localparam int          SM3_LEN_WORD_HI = 14;
    localparam logic [31:0] SM3_PAD_MARK    = 32'h8000_0000;

    typedef enum logic [2:0] {
        DATA,
        PAD_ONE,
        PAD_ZERO,
        LEN_HI,
        LEN_LO
    } pad_st_t;

    // Number of set bits in a 4-bit lane byte mask (0..4).
    function automatic logic [2:0] pop4(input logic [3:0] m);
        pop4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/sm3_pad_lane_mark.sv
// Keeps the first nbyte_i bytes of a 32-bit lane, places the 0x80 marker in
// the next byte and zeroes the rest. A full lane (4 bytes) passes unchanged.
module sm3_pad_lane_mark
    import sm3_pkg::*;
(
    input  logic [31:0] lane_i,
    input  logic [2:0]  nbyte_i,
    output logic [31:0] word_o
);

    // Byte-count driven masking and marker insertion.
    always_comb begin
        case (nbyte_i)
            3'd0:    word_o = SM3_PAD_MARK;
            3'd1:    word_o = {lane_i[31:24], 8'h80, 16'h0000};
            3'd2:    word_o = {lane_i[31:16], 8'h80, 8'h00};
            3'd3:    word_o = {lane_i[31:8], 8'h80};
            default: word_o = lane_i;
        endcase
    end

endmodule

// File: rtl/sm3_pad_core_p.sv
// SM3 message padder with a 32- or 64-bit input beat and a 32-bit word output.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// DATA     | stream message words; the lst beat places the 0x80 marker
// PAD_ONE  | message ended on a full lane; emit the 0x80000000 marker word
// PAD_ZERO | zero fill until the slot before the length field
// LEN_HI   | emit bit length [63:32] at word 14
// LEN_LO   | emit bit length [31:0] at word 15 with lst, then restart
module sm3_pad_core_p
    import sm3_pkg::*;
#(
    parameter int INPT_DW = 32,
    parameter int LEN_W   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INPT_DW-1:0]   msg_inpt_d_i,
    input  logic [INPT_DW/8-1:0] msg_inpt_vld_byte_i,
    input  logic                 msg_inpt_vld_i,
    input  logic                 msg_inpt_lst_i,
    output logic                 msg_inpt_rdy_o,
    input  logic                 pad_otpt_ena_i,
    output logic [31:0]          pad_otpt_d_o,
    output logic                 pad_otpt_vld_o,
    output logic                 pad_otpt_blk_lst_o,
    output logic                 pad_otpt_lst_o
);

    localparam int         NB        = INPT_DW / 8;
    localparam bit         HAS_LO    = (INPT_DW == 64);
    localparam logic [3:0] WC_PRE_HI = 4'(SM3_LEN_WORD_HI - 1);
    localparam logic [3:0] WC_LAST   = 4'(SM3_BLK_WORDS - 1);

    pad_st_t          state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [31:0]      out_d_q, out_d_d;
    logic             out_vld_q, out_vld_d;
    logic             out_blk_q, out_blk_d;
    logic             out_lst_q, out_lst_d;

    logic [31:0]      lane_hi, lane_lo, mark_hi, mark_lo;
    logic [2:0]       nb_hi, nb_lo;
    logic [3:0]       nb_sum;
    logic [LEN_W-1:0] len_add;
    logic [63:0]      len64;
    logic             load_en, rdy, accept, load, word_lst;
    logic [31:0]      word;

    assign lane_hi = msg_inpt_d_i[INPT_DW-1 -: 32];
    assign nb_hi   = pop4(msg_inpt_vld_byte_i[NB-1 -: 4]);

    generate
        if (HAS_LO) begin : g_lo
            assign lane_lo = msg_inpt_d_i[31:0];
            assign nb_lo   = pop4(msg_inpt_vld_byte_i[3:0]);
        end else begin : g_no_lo
            assign lane_lo = '0;
            assign nb_lo   = '0;
        end
    endgenerate

    sm3_pad_lane_mark u_mark_hi (.lane_i(lane_hi), .nbyte_i(nb_hi), .word_o(mark_hi));
    sm3_pad_lane_mark u_mark_lo (.lane_i(lane_lo), .nbyte_i(nb_lo), .word_o(mark_lo));

    assign nb_sum  = {1'b0, nb_hi} + {1'b0, nb_lo};
    assign len_add = LEN_W'({nb_sum, 3'b000});
    assign len64   = 64'(len_q);

    assign load_en = !out_vld_q | pad_otpt_ena_i;
    assign rdy     = (state_q == DATA) & !pend_vld_q & load_en;
    assign accept  = msg_inpt_vld_i & rdy;

    // Next-state, word selection and output-register load decision.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        len_d      = len_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        out_d_d    = out_d_q;
        out_vld_d  = out_vld_q & !pad_otpt_ena_i;
        out_blk_d  = out_blk_q & !pad_otpt_ena_i;
        out_lst_d  = out_lst_q & !pad_otpt_ena_i;
        load       = 1'b0;
        word       = '0;
        word_lst   = 1'b0;

        if (load_en) begin
            if (pend_vld_q) begin
                // The lower lane always goes out before any pad word.
                load       = 1'b1;
                word       = pend_q;
                pend_vld_d = 1'b0;
                if (state_q == PAD_ZERO && wcnt_q == WC_PRE_HI) begin
                    state_d = LEN_HI;
                end
            end else begin
                case (state_q)
                    DATA: begin
                        if (accept) begin
                            load  = 1'b1;
                            len_d = len_q + len_add;
                            if (!msg_inpt_lst_i) begin
                                word = lane_hi;
                                if (HAS_LO) begin
                                    pend_d     = lane_lo;
                                    pend_vld_d = 1'b1;
                                end
                            end else if (nb_hi != 3'd4) begin
                                word    = mark_hi;
                                state_d = (wcnt_q == WC_PRE_HI) ? LEN_HI : PAD_ZERO;
                            end else begin
                                word = lane_hi;
                                if (HAS_LO) begin
                                    pend_d     = mark_lo;
                                    pend_vld_d = 1'b1;
                                    state_d    = (nb_lo != 3'd4) ? PAD_ZERO : PAD_ONE;
                                end else begin
                                    state_d = PAD_ONE;
                                end
                            end
                        end
                    end
                    PAD_ONE: begin
                        load    = 1'b1;
                        word    = SM3_PAD_MARK;
                        state_d = (wcnt_q == WC_PRE_HI) ? LEN_HI : PAD_ZERO;
                    end
                    PAD_ZERO: begin
                        load    = 1'b1;
                        word    = '0;
                        state_d = (wcnt_q == WC_PRE_HI) ? LEN_HI : PAD_ZERO;
                    end
                    LEN_HI: begin
                        load    = 1'b1;
                        word    = len64[63:32];
                        state_d = LEN_LO;
                    end
                    LEN_LO: begin
                        // Length is captured in the output word, so it can restart now.
                        load     = 1'b1;
                        word     = len64[31:0];
                        word_lst = 1'b1;
                        len_d    = '0;
                        state_d  = DATA;
                    end
                    default: state_d = DATA;
                endcase
            end
        end

        if (load) begin
            out_d_d   = word;
            out_vld_d = 1'b1;
            out_blk_d = (wcnt_q == WC_LAST);
            out_lst_d = word_lst;
            wcnt_d    = wcnt_q + 4'd1;
        end
    end

    // State, counters, pending lane and output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DATA;
            wcnt_q     <= '0;
            len_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            out_d_q    <= '0;
            out_vld_q  <= 1'b0;
            out_blk_q  <= 1'b0;
            out_lst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            len_q      <= len_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            out_d_q    <= out_d_d;
            out_vld_q  <= out_vld_d;
            out_blk_q  <= out_blk_d;
            out_lst_q  <= out_lst_d;
        end
    end

    assign msg_inpt_rdy_o     = rdy;
    assign pad_otpt_d_o       = out_d_q;
    assign pad_otpt_vld_o     = out_vld_q;
    assign pad_otpt_blk_lst_o = out_blk_q;
    assign pad_otpt_lst_o     = out_lst_q;

endmodule

// File: tb/tb_sm3_pad_core_p.sv
// Bench for sm3_pad_core_p: one 32-bit and one 64-bit instance, a byte-level
// SM3 padding reference model, directed vectors and randomized messages.
module tb_sm3_pad_core_p;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] msg_d;
    logic [7:0]  msk;
    logic        vld, lst, ena;
    bit          sel64;

    logic [31:0] d32, d64;
    logic        rdy32, rdy64, vld32, vld64, blk32, blk64, lst32, lst64;
    logic [31:0] o_d;
    logic        o_rdy, o_vld, o_blk, o_lst;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    always #5 clk = ~clk;

    sm3_pad_core_p #(.INPT_DW(32), .LEN_W(64)) u_dut32 (
        .clk(clk), .rst(rst),
        .msg_inpt_d_i(msg_d[63:32]), .msg_inpt_vld_byte_i(msk[7:4]),
        .msg_inpt_vld_i(vld & !sel64), .msg_inpt_lst_i(lst), .msg_inpt_rdy_o(rdy32),
        .pad_otpt_ena_i(ena), .pad_otpt_d_o(d32), .pad_otpt_vld_o(vld32),
        .pad_otpt_blk_lst_o(blk32), .pad_otpt_lst_o(lst32)
    );

    sm3_pad_core_p #(.INPT_DW(64), .LEN_W(64)) u_dut64 (
        .clk(clk), .rst(rst),
        .msg_inpt_d_i(msg_d), .msg_inpt_vld_byte_i(msk),
        .msg_inpt_vld_i(vld & sel64), .msg_inpt_lst_i(lst), .msg_inpt_rdy_o(rdy64),
        .pad_otpt_ena_i(ena), .pad_otpt_d_o(d64), .pad_otpt_vld_o(vld64),
        .pad_otpt_blk_lst_o(blk64), .pad_otpt_lst_o(lst64)
    );

    assign o_d   = sel64 ? d64 : d32;
    assign o_rdy = sel64 ? rdy64 : rdy32;
    assign o_vld = sel64 ? vld64 : vld32;
    assign o_blk = sel64 ? blk64 : blk32;
    assign o_lst = sel64 ? lst64 : lst32;

    typedef struct {
        bit          w64;
        int          nbytes;
        byte unsigned base;
        bit          inc;
        int          exp_n;
        logic [31:0] exp_w0;
        int          mid;
        logic [31:0] exp_mid;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SM3 padding straight from the byte-level rule: append 0x80, zero to 56 mod 64,
    // then the 64-bit big-endian bit length; cut into 32-bit words.
    task automatic build_model(input byte unsigned m[$]);
        byte unsigned p[$];
        logic [63:0]  bl;
        p = m;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        exp_q.delete();
        for (int i = 0; i < p.size(); i += 4)
            exp_q.push_back({p[i], p[i+1], p[i+2], p[i+3]});
    endtask

    task automatic run_msg(input bit w64, input byte unsigned m[$], input bit rnd_ena, input int abort_at);
        int          bw, nbeats, beat, idx, cyc, n, pos;
        bit          acc, prev_acc, held;
        logic [31:0] held_d;
        logic        held_b, held_l;
        bw     = w64 ? 8 : 4;
        nbeats = (m.size() + bw - 1) / bw;
        if (nbeats == 0) nbeats = 1;
        build_model(m);
        n = exp_q.size();
        got_q.delete();
        sel64 = w64;
        beat = 0; idx = 0; cyc = 0; prev_acc = 0; held = 0;
        held_d = '0; held_b = 0; held_l = 0;
        while (idx < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                chk("hold_d", o_d, held_d);
                chk("hold_flags", {o_vld, o_blk, o_lst}, {1'b1, held_b, held_l});
            end
            if (w64 && prev_acc) chk("rdy_pending", o_rdy, 0);
            ena = rnd_ena ? 1'($urandom_range(0, 1)) : 1'b1;
            if (beat < nbeats) begin
                vld = 1'b1;
                lst = (beat == nbeats - 1);
                msk = '0;
                for (int k = 0; k < bw; k++) begin
                    pos = beat * bw + k;
                    if (pos < m.size()) begin
                        msg_d[63-8*k -: 8] = m[pos];
                        msk[7-k] = 1'b1;
                    end else begin
                        msg_d[63-8*k -: 8] = 8'($urandom);
                    end
                end
            end else begin
                vld = 1'b0;
                lst = 1'b0;
            end
            #1;
            acc = vld & o_rdy;
            if (o_vld & ena) begin
                got_q.push_back(o_d);
                chk($sformatf("word%0d", idx), o_d, exp_q[idx]);
                chk($sformatf("blk_lst%0d", idx), o_blk, (idx % 16) == 15);
                chk($sformatf("lst%0d", idx), o_lst, idx == n - 1);
                idx++;
            end
            held   = o_vld & !ena;
            held_d = o_d;
            held_b = o_blk;
            held_l = o_lst;
            prev_acc = acc;
            if (acc) beat++;
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b1;
                vld = 1'b0;
                lst = 1'b0;
                @(negedge clk);
                chk("rst_vld", o_vld, 0);
                chk("rst_d", o_d, 0);
                chk("rst_flags", {o_blk, o_lst}, 0);
                chk("rst_rdy", o_rdy, 1);
                rst = 1'b0;
                return;
            end
        end
        chk("word_count", idx, n);
        @(negedge clk);
        vld = 1'b0;
        ena = 1'b1;
        #1;
        chk("no_extra", o_vld, 0);
    endtask

    task automatic apply_vec(input int v, input bit rnd_ena);
        byte unsigned m[$];
        for (int i = 0; i < vt[v].nbytes; i++)
            m.push_back(vt[v].inc ? 8'(vt[v].base + i) : vt[v].base);
        run_msg(vt[v].w64, m, rnd_ena, -1);
        chk($sformatf("vec%0d_n", v), got_q.size(), vt[v].exp_n);
        chk($sformatf("vec%0d_w0", v), got_q[0], vt[v].exp_w0);
        chk($sformatf("vec%0d_mid", v), got_q[vt[v].mid], vt[v].exp_mid);
        chk($sformatf("vec%0d_last", v), got_q[got_q.size()-1], vt[v].exp_last);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        byte unsigned mq[$];
        int           len;

        //          w64 nbytes base  inc n   w0            mid mid_val       last
        vt[0] = '{1'b0,  3, 8'h61, 1'b1, 16, 32'h61626380, 14, 32'h00000000, 32'h00000018};
        vt[1] = '{1'b0, 56, 8'h61, 1'b0, 32, 32'h61616161, 14, 32'h80000000, 32'h000001C0};
        vt[2] = '{1'b1,  4, 8'h61, 1'b1, 16, 32'h61626364,  1, 32'h80000000, 32'h00000020};
        vt[3] = '{1'b0,  0, 8'h00, 1'b0, 16, 32'h80000000, 14, 32'h00000000, 32'h00000000};
        vt[4] = '{1'b1,  0, 8'h00, 1'b0, 16, 32'h80000000, 14, 32'h00000000, 32'h00000000};
        vt[5] = '{1'b1, 56, 8'h61, 1'b0, 32, 32'h61616161, 14, 32'h80000000, 32'h000001C0};
        vt[6] = '{1'b0, 55, 8'h61, 1'b0, 16, 32'h61616161, 13, 32'h61616180, 32'h000001B8};
        vt[7] = '{1'b1, 60, 8'h00, 1'b1, 32, 32'h00010203, 15, 32'h80000000, 32'h000001E0};
        vt[8] = '{1'b0, 58, 8'h10, 1'b1, 32, 32'h10111213, 14, 32'h48498000, 32'h000001D0};

        sel64 = 1'b0;
        rst   = 1'b1;
        vld   = 1'b0;
        lst   = 1'b0;
        ena   = 1'b0;
        msg_d = '0;
        msk   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out32", {d32, vld32, blk32, lst32}, 0);
        chk("reset_out64", {d64, vld64, blk64, lst64}, 0);
        chk("reset_rdy", {rdy32, rdy64}, 2'b11);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) apply_vec(v, 1'b0);

        // Backpressure on "abc" and on a two-block 64-bit message.
        apply_vec(0, 1'b1);
        apply_vec(7, 1'b1);

        // Reset while the 56-byte message is mid-block, then "abc" must be clean.
        mq.delete();
        for (int i = 0; i < 56; i++) mq.push_back(8'h61);
        run_msg(1'b0, mq, 1'b0, 5);
        apply_vec(0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            mq.delete();
            len = $urandom_range(0, 140);
            for (int i = 0; i < len; i++) mq.push_back(8'($urandom));
            run_msg(1'($urandom_range(0, 1)), mq, 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
